ram_arbiter_2p: RTL and testbench

- Shares the single-port 16-bit synchronous RAM between two requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Selects at most one request per cycle and drives the RAM control inputs combinationally, so the RAM samples the winning request on the same clock edge.
- Tracks the 1-cycle read latency and returns read data with a valid strobe to the port that issued the read.
- Supports round-robin or fixed priority, and a bounded lock so one port can hold the RAM for back-to-back accesses, e.g. read-modify-write.

---
 rtl/ram_arbiter_2p.sv | 142 ++++++++++++++
 tb/tb_ram_arbiter_2p.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_2p.sv
// Two-port arbiter in front of a single-port synchronous RAM.
// Port 0 is instruction fetch and port 1 is data load/store. At most one
// request is granted per cycle. The RAM control inputs are driven
// combinationally from the winner, so the RAM samples that request on the
// same clock edge.
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   reqN/weN/addrN/wdataN  per-port request, write enable, address, write data
//   lockN                  ask to keep the grant on the following cycle
//   gntN                   combinational grant; the request is consumed on this edge
//   rvalidN, rdata         read return, one cycle after the read grant
//   ram_*                  RAM control, address and data
module ram_arbiter_2p #(
  parameter int unsigned AW        = 6,
  parameter int unsigned DW        = 16,
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned MAX_LOCK  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_add,
  output logic [DW-1:0] ram_data_in,
  output logic          ram_r_w,
  output logic          ram_enable,
  output logic          ram_ce,
  input  logic [DW-1:0] ram_data_out
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {OWN_NONE, OWN_P0, OWN_P1} owner_t;

  owner_t        owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;    // 1 = port 1 granted most recently
  logic          rvalid0_q, rvalid1_q;
  logic          g0, g1;
  logic          hold0, hold1, at_max, forced;

  // Lock owner, lock count, round-robin pointer and read-return flags
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= OWN_NONE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      rvalid0_q <= g0 & ~we0;
      rvalid1_q <= g1 & ~we1;
    end
  end

  // Arbitration and next lock state
  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    g0      = 1'b0;
    g1      = 1'b0;
    forced  = 1'b0;
    hold0   = (owner_q == OWN_P0) && req0 && lock0;
    hold1   = (owner_q == OWN_P1) && req1 && lock1;
    at_max  = (cnt_q >= CW'(MAX_LOCK));

    if (rst) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end else if (hold0) begin
      // Once the lock budget is used up, the waiting port gets one grant
      if (at_max && req1) begin
        g1     = 1'b1;
        forced = 1'b1;
      end else begin
        g0 = 1'b1;
      end
    end else if (hold1) begin
      if (at_max && req0) begin
        g0     = 1'b1;
        forced = 1'b1;
      end else begin
        g1 = 1'b1;
      end
    end else if (req0 && req1) begin
      if ((PRIO_MODE == 1) || last_q) g0 = 1'b1;
      else                            g1 = 1'b1;
    end else begin
      g0 = req0;
      g1 = req1;
    end

    // The lock count advances only on grants taken while the other port waits
    if (forced) begin
      owner_d = OWN_NONE;
      cnt_d   = '0;
    end else if (g0 && lock0) begin
      owner_d = OWN_P0;
      cnt_d   = ((owner_q == OWN_P0) ? cnt_q : CW'(0)) + (req1 ? CW'(1) : CW'(0));
    end else if (g1 && lock1) begin
      owner_d = OWN_P1;
      cnt_d   = ((owner_q == OWN_P1) ? cnt_q : CW'(0)) + (req0 ? CW'(1) : CW'(0));
    end else begin
      owner_d = OWN_NONE;
      cnt_d   = '0;
    end

    if (g0) last_d = 1'b0;
    if (g1) last_d = 1'b1;
  end

  assign gnt0        = g0;
  assign gnt1        = g1;
  assign ram_enable  = g0 | g1;
  assign ram_ce      = ~rst;
  assign ram_add     = g1 ? addr1  : addr0;
  assign ram_data_in = g1 ? wdata1 : wdata0;
  assign ram_r_w     = g1 ? we1    : we0;

  // A read return already in flight is hidden while reset is high
  assign rvalid0 = rvalid0_q & ~rst;
  assign rvalid1 = rvalid1_q & ~rst;
  assign rdata   = ram_data_out;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
module tb_ram_arbiter_2p;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata, ram_data_in, ram_data_out;
  logic [AW-1:0] ram_add;
  logic          ram_r_w, ram_enable, ram_ce;

  // Second instance in fixed-priority mode
  logic          f_req0, f_req1;
  logic          f_gnt0, f_gnt1, f_rvalid0, f_rvalid1;
  logic [DW-1:0] f_rdata, f_ram_data_in;
  logic [DW-1:0] f_ram_data_out = '0;
  logic [AW-1:0] f_ram_add;
  logic          f_ram_r_w, f_ram_enable, f_ram_ce;

  logic [DW-1:0] mem [64];
  logic [DW:0]   sb [$];   // {port, data}
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  ram_arbiter_2p #(.AW(AW), .DW(DW), .PRIO_MODE(0), .MAX_LOCK(2)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .ram_add(ram_add), .ram_data_in(ram_data_in),
    .ram_r_w(ram_r_w), .ram_enable(ram_enable), .ram_ce(ram_ce),
    .ram_data_out(ram_data_out)
  );

  ram_arbiter_2p #(.AW(AW), .DW(DW), .PRIO_MODE(1), .MAX_LOCK(4)) u_fp (
    .clk(clk), .rst(rst),
    .req0(f_req0), .req1(f_req1), .we0(1'b0), .we1(1'b0),
    .addr0(6'd1), .addr1(6'd2), .wdata0(16'h0), .wdata1(16'h0),
    .lock0(1'b0), .lock1(1'b0),
    .gnt0(f_gnt0), .gnt1(f_gnt1), .rvalid0(f_rvalid0), .rvalid1(f_rvalid1),
    .rdata(f_rdata), .ram_add(f_ram_add), .ram_data_in(f_ram_data_in),
    .ram_r_w(f_ram_r_w), .ram_enable(f_ram_enable), .ram_ce(f_ram_ce),
    .ram_data_out(f_ram_data_out)
  );

  // Single-port synchronous RAM with registered read data
  always @(posedge clk) begin
    if (ram_ce && ram_enable) begin
      if (ram_r_w) mem[ram_add] <= ram_data_in;
      else         ram_data_out <= mem[ram_add];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every read return is matched against the scoreboard
  always @(negedge clk) begin
    if (rvalid0 || rvalid1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rv_unexpected: got rvalid={%b,%b}, expected none at %0t",
                 rvalid1, rvalid0, $time);
      end else begin
        logic [DW:0] e;
        e = sb.pop_front();
        chk("rv_port", 32'({rvalid1, rvalid0}), 32'({e[DW], ~e[DW]}));
        chk("rdata", 32'(rdata), 32'(e[DW-1:0]));
      end
    end
  end

  // One cycle: drive at posedge+1, check grants and RAM drive at negedge
  task automatic step(input string nm,
                      input logic r0, input logic w0, input logic [AW-1:0] a0,
                      input logic [DW-1:0] d0, input logic l0,
                      input logic r1, input logic w1, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d1, input logic l1,
                      input logic eg0, input logic eg1, input logic [DW-1:0] ed);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; lock0 = l0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
    @(negedge clk);
    chk({nm, "_gnt0"}, 32'(gnt0), 32'(eg0));
    chk({nm, "_gnt1"}, 32'(gnt1), 32'(eg1));
    chk({nm, "_en"}, 32'(ram_enable), 32'(eg0 | eg1));
    if (eg0 || eg1) begin
      chk({nm, "_add"}, 32'(ram_add), 32'(eg1 ? a1 : a0));
      chk({nm, "_rw"}, 32'(ram_r_w), 32'(eg1 ? w1 : w0));
      if (eg1 && w1) chk({nm, "_wd"}, 32'(ram_data_in), 32'(d1));
      if ((eg0 && !w0) || (eg1 && !w1)) sb.push_back({eg1, ed});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'hA000 + 16'(i);
    mem[5] = 16'h1234;
    rst = 1'b1;
    req0 = 1'b1; we0 = 0; addr0 = 6'd5; wdata0 = 0; lock0 = 0;
    req1 = 1'b1; we1 = 0; addr1 = 6'd2; wdata1 = 0; lock1 = 0;
    f_req0 = 0; f_req1 = 0;

    // Reset state with both requests held
    @(negedge clk); @(negedge clk);
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_en", 32'(ram_enable), 0);
    chk("rst_ce", 32'(ram_ce), 0);
    chk("rst_rv", 32'({rvalid1, rvalid0}), 0);
    @(posedge clk); #1;
    rst = 1'b0; req0 = 0; req1 = 0;
    @(negedge clk);
    chk("post_ce", 32'(ram_ce), 1);
    chk("post_en", 32'(ram_enable), 0);
    @(posedge clk); #1;

    // Port 0 alone reads addr 5
    step("t1", 1, 0, 6'd5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h1234);
    // Port 1 writes, then port 0 reads the same address next cycle
    step("t4w", 0, 0, 0, 0, 0, 1, 1, 6'd9, 16'hBEEF, 0, 0, 1, 16'h0);
    step("t4r", 1, 0, 6'd9, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'hBEEF);
    step("p1solo", 0, 0, 0, 0, 0, 1, 0, 6'd7, 0, 0, 0, 1, 16'hA007);

    // Round-robin alternation
    step("rr0", 1, 0, 6'd1, 0, 0, 1, 0, 6'd2, 0, 0, 1, 0, 16'hA001);
    step("rr1", 1, 0, 6'd1, 0, 0, 1, 0, 6'd2, 0, 0, 0, 1, 16'hA002);
    step("rr2", 1, 0, 6'd1, 0, 0, 1, 0, 6'd2, 0, 0, 1, 0, 16'hA001);
    step("rr3", 1, 0, 6'd1, 0, 0, 1, 0, 6'd2, 0, 0, 0, 1, 16'hA002);
    step("p0solo", 1, 0, 6'd4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'hA004);

    // Lock held by port 1 with port 0 waiting, MAX_LOCK = 2
    step("lk0", 1, 0, 6'd4, 0, 0, 1, 0, 6'd3, 0, 1, 0, 1, 16'hA003);
    step("lk1", 1, 0, 6'd4, 0, 0, 1, 0, 6'd3, 0, 1, 0, 1, 16'hA003);
    step("lk2", 1, 0, 6'd4, 0, 0, 1, 0, 6'd3, 0, 1, 1, 0, 16'hA004);
    step("lk3", 1, 0, 6'd4, 0, 0, 1, 0, 6'd3, 0, 1, 0, 1, 16'hA003);
    step("lk4", 1, 0, 6'd4, 0, 0, 1, 0, 6'd3, 0, 1, 0, 1, 16'hA003);
    step("lk5", 1, 0, 6'd4, 0, 0, 1, 0, 6'd3, 0, 1, 1, 0, 16'hA004);
    step("lk6", 1, 0, 6'd4, 0, 0, 1, 0, 6'd3, 0, 0, 0, 1, 16'hA003);
    step("lk7", 1, 0, 6'd4, 0, 0, 1, 0, 6'd3, 0, 0, 1, 0, 16'hA004);

    // Solo grants under lock do not use up the lock budget
    step("sl0", 0, 0, 0, 0, 0, 1, 0, 6'd3, 0, 1, 0, 1, 16'hA003);
    step("sl1", 0, 0, 0, 0, 0, 1, 0, 6'd3, 0, 1, 0, 1, 16'hA003);
    step("sl2", 0, 0, 0, 0, 0, 1, 0, 6'd3, 0, 1, 0, 1, 16'hA003);
    step("sl3", 1, 0, 6'd6, 0, 0, 1, 0, 6'd3, 0, 1, 0, 1, 16'hA003);
    step("sl4", 1, 0, 6'd6, 0, 0, 1, 0, 6'd3, 0, 1, 0, 1, 16'hA003);
    step("sl5", 1, 0, 6'd6, 0, 0, 1, 0, 6'd3, 0, 1, 1, 0, 16'hA006);
    step("sl6", 1, 0, 6'd6, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'hA006);
    step("sl7", 1, 0, 6'd6, 0, 0, 1, 0, 6'd3, 0, 0, 0, 1, 16'hA003);
    idle();

    // Fixed priority: port 0 wins every contention
    f_req0 = 1; f_req1 = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fp_gnt0", 32'(f_gnt0), 1);
      chk("fp_gnt1", 32'(f_gnt1), 0);
      if (i > 0) chk("fp_rv", 32'({f_rvalid1, f_rvalid0}), 1);
      @(posedge clk); #1;
    end
    f_req0 = 0; f_req1 = 0;
    idle();

    // Reset right after a port-0 read grant: that read never returns
    req0 = 1; we0 = 0; addr0 = 6'd5; lock0 = 0; req1 = 0;
    @(negedge clk);
    chk("pre_rst_gnt0", 32'(gnt0), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    req1 = 1; addr1 = 6'd2; we1 = 0;
    @(negedge clk);
    chk("mid_rst_rv0", 32'(rvalid0), 0);
    chk("mid_rst_en", 32'(ram_enable), 0);
    chk("mid_rst_gnt0", 32'(gnt0), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_rv0b", 32'(rvalid0), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    step("ar0", 1, 0, 6'd5, 0, 0, 1, 0, 6'd2, 0, 0, 1, 0, 16'h1234);
    step("ar1", 1, 0, 6'd5, 0, 0, 1, 0, 6'd2, 0, 0, 0, 1, 16'hA002);
    idle();
    idle();
    idle();

    chk("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
